clk_ratio_detector: RTL and testbench

- Receiving-end companion to the master-clock divider.
- Takes one divided-clock-like signal, sampled in the master clock domain, and measures its period and high time in master-clock cycles.
- Declares lock once the period is stable and decodes power-of-two ratios 2/4/8/16/32.
- Used as a built-in checker on divider outputs and on externally supplied slow clocks.

---
 rtl/clk_ratio_detector.sv | 162 ++++++++++++++++
 tb/tb_clk_ratio_detector.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_ratio_detector.sv
// Measures period and high time of a slow clock-like input in master-clock cycles,
// declares lock on a stable period and decodes power-of-two ratios 2..32.
module clk_ratio_detector #(
    parameter int MAX_PERIOD = 64,
    parameter int LOCK_COUNT = 4,
    localparam int W = $clog2(MAX_PERIOD + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sig_in,
    output logic [W-1:0] period,
    output logic [W-1:0] high_time,
    output logic         period_valid,
    output logic         locked,
    output logic [4:0]   ratio_onehot,
    output logic         duty_ok,
    output logic         timeout
);

    // Internal counters need one extra count so the timeout threshold is representable.
    localparam int CW = $clog2(MAX_PERIOD + 2);
    localparam logic [CW-1:0] TO_LIMIT = CW'(MAX_PERIOD + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [CW-1:0] elapsed_q, elapsed_d;
    logic [CW-1:0] hi_acc_q, hi_acc_d;
    logic [W-1:0]  period_q, period_d;
    logic [W-1:0]  high_time_q, high_time_d;
    logic [W-1:0]  prev_period_q, prev_period_d;
    logic [3:0]    match_cnt_q, match_cnt_d;
    logic          period_valid_q, period_valid_d;
    logic          locked_q, locked_d;
    logic [4:0]    ratio_q, ratio_d;
    logic          duty_ok_q, duty_ok_d;
    logic          timeout_q, timeout_d;
    logic          rise;
    logic [W-1:0]  p_meas;
    logic          p_match;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == TO_LIMIT) ? v : v + CW'(1);
    endfunction

    function automatic logic [4:0] ratio_of(input logic [W-1:0] p);
        logic [4:0] r;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            r[i] = (int'(p) == (2 << i));
        end
        return r;
    endfunction

    always_comb begin
        s1_d           = sig_in;
        s2_d           = s1_q;
        s3_d           = s2_q;
        rise           = s2_q & ~s3_q;
        p_meas         = elapsed_q[W-1:0];
        p_match        = (p_meas == prev_period_q);

        state_d        = state_q;
        elapsed_d      = sat_inc(elapsed_q);
        hi_acc_d       = s2_q ? sat_inc(hi_acc_q) : hi_acc_q;
        period_d       = period_q;
        high_time_d    = high_time_q;
        prev_period_d  = prev_period_q;
        match_cnt_d    = match_cnt_q;
        period_valid_d = 1'b0;
        locked_d       = locked_q;
        duty_ok_d      = duty_ok_q;
        timeout_d      = 1'b0;

        // The rise cycle is cycle 0 of the new window, so both counters restart at 1.
        if (state_q != IDLE && elapsed_q == TO_LIMIT) begin
            timeout_d   = 1'b1;
            locked_d    = 1'b0;
            match_cnt_d = '0;
            state_d     = IDLE;
        end else if (rise) begin
            elapsed_d = CW'(1);
            hi_acc_d  = CW'(1);
            if (state_q == IDLE) begin
                state_d = MEASURE;
            end else begin
                period_d       = p_meas;
                high_time_d    = hi_acc_q[W-1:0];
                duty_ok_d      = ({hi_acc_q, 1'b0} == {1'b0, elapsed_q});
                period_valid_d = 1'b1;
                prev_period_d  = p_meas;
                if (state_q == MEASURE) begin
                    if (p_match) begin
                        match_cnt_d = match_cnt_q + 4'd1;
                        if (int'(match_cnt_q) + 1 == LOCK_COUNT) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end
                    end else begin
                        match_cnt_d = '0;
                    end
                end else if (!p_match) begin
                    locked_d    = 1'b0;
                    match_cnt_d = '0;
                    state_d     = MEASURE;
                end
            end
        end

        ratio_d = locked_d ? ratio_of(period_d) : 5'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            s1_q           <= 1'b0;
            s2_q           <= 1'b0;
            s3_q           <= 1'b0;
            elapsed_q      <= '0;
            hi_acc_q       <= '0;
            period_q       <= '0;
            high_time_q    <= '0;
            prev_period_q  <= '0;
            match_cnt_q    <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            ratio_q        <= '0;
            duty_ok_q      <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            s1_q           <= s1_d;
            s2_q           <= s2_d;
            s3_q           <= s3_d;
            elapsed_q      <= elapsed_d;
            hi_acc_q       <= hi_acc_d;
            period_q       <= period_d;
            high_time_q    <= high_time_d;
            prev_period_q  <= prev_period_d;
            match_cnt_q    <= match_cnt_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            ratio_q        <= ratio_d;
            duty_ok_q      <= duty_ok_d;
            timeout_q      <= timeout_d;
        end
    end

    assign period       = period_q;
    assign high_time    = high_time_q;
    assign period_valid = period_valid_q;
    assign locked       = locked_q;
    assign ratio_onehot = ratio_q;
    assign duty_ok      = duty_ok_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_clk_ratio_detector.sv
// Bench for clk_ratio_detector: directed waveforms plus random waves/glitches/resets,
// every cycle compared against an event-level reference model.
module tb_clk_ratio_detector;

    localparam int MAXP  = 64;
    localparam int LOCKN = 4;
    localparam int W     = $clog2(MAXP + 1);
    localparam int HIST  = 40000;

    logic         clk;
    logic         rst;
    logic         sig_in;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         period_valid;
    logic         locked;
    logic [4:0]   ratio_onehot;
    logic         duty_ok;
    logic         timeout;

    clk_ratio_detector #(.MAX_PERIOD(MAXP), .LOCK_COUNT(LOCKN)) dut (
        .clk          (clk),
        .rst          (rst),
        .sig_in       (sig_in),
        .period       (period),
        .high_time    (high_time),
        .period_valid (period_valid),
        .locked       (locked),
        .ratio_onehot (ratio_onehot),
        .duty_ok      (duty_ok),
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n     = 0;

    // xs[e] is the input level captured by the synchronizer at edge e (0 on reset edges)
    bit xs [0:HIST-1];

    // reference model: 0 = waiting for first edge, 1 = measuring, 2 = locked
    int   m_mode;
    int   m_last;
    int   m_prev;
    int   m_matches;
    int   m_period;
    int   m_high;
    bit   m_pv, m_locked, m_duty, m_to;
    logic [4:0] m_ratio;

    // bench-side observations of the DUT
    int pv_cnt, lock_pv, last_pv_n, to_dist;
    bit lock_seen;
    bit watch8, first8_locked;
    logic [4:0] first8_ratio;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, n);
        end
    endtask

    function automatic void model_edge(input bit r);
        bit rise;
        int p, hi;
        m_pv = 1'b0;
        m_to = 1'b0;
        if (r) begin
            m_mode = 0; m_last = n; m_prev = 0; m_matches = 0;
            m_period = 0; m_high = 0; m_locked = 0; m_duty = 0; m_ratio = '0;
            return;
        end
        rise = (n >= 3) && xs[n-2] && !xs[n-3];
        if (m_mode != 0 && (n - m_last) == MAXP + 1) begin
            m_to = 1'b1; m_locked = 1'b0; m_matches = 0; m_mode = 0;
        end else if (rise) begin
            if (m_mode == 0) begin
                m_mode = 1;
            end else begin
                p  = n - m_last;
                hi = 0;
                for (int k = m_last; k < n; k++) hi += int'(xs[k-2]);
                m_period = p;
                m_high   = hi;
                m_duty   = (2 * hi == p);
                m_pv     = 1'b1;
                if (m_mode == 1) begin
                    if (p == m_prev) begin
                        m_matches++;
                        if (m_matches == LOCKN) begin
                            m_mode = 2; m_locked = 1'b1;
                        end
                    end else begin
                        m_matches = 0;
                    end
                end else if (p != m_prev) begin
                    m_locked = 1'b0; m_matches = 0; m_mode = 1;
                end
                m_prev = p;
            end
            m_last = n;
        end
        m_ratio = '0;
        if (m_locked)
            for (int i = 0; i < 5; i++) m_ratio[i] = (m_period == (2 << i));
    endfunction

    task automatic step(input bit v, input bit r);
        sig_in = v;
        rst    = r;
        @(posedge clk);
        n++;
        if (n >= HIST) begin
            $display("FAIL history: cycle budget exceeded at cycle %0d", n);
            $fatal(1, "cycle budget exceeded");
        end
        xs[n] = r ? 1'b0 : v;
        model_edge(r);
        @(negedge clk);
        chk("period",       period,       m_period);
        chk("high_time",    high_time,    m_high);
        chk("period_valid", period_valid, m_pv);
        chk("locked",       locked,       m_locked);
        chk("ratio_onehot", ratio_onehot, m_ratio);
        chk("duty_ok",      duty_ok,      m_duty);
        chk("timeout",      timeout,      m_to);
        if (r) begin
            pv_cnt = 0; lock_seen = 0; lock_pv = -1;
        end
        if (period_valid) begin
            pv_cnt++;
            last_pv_n = n;
            if (watch8 && period == W'(8)) begin
                watch8 = 0; first8_locked = locked; first8_ratio = ratio_onehot;
                pv_cnt = 0; lock_seen = 0; lock_pv = -1;
            end
        end
        if (locked && !lock_seen) begin
            lock_seen = 1; lock_pv = pv_cnt;
        end
        if (timeout) to_dist = n - last_pv_n;
    endtask

    task automatic wave(input int hi, input int lo, input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < hi; i++) step(1'b1, 1'b0);
            for (int i = 0; i < lo; i++) step(1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
    endtask

    initial begin
        int pvb, p, h, reps;
        rst = 1'b1; sig_in = 1'b0;
        lock_pv = -1; pv_cnt = 0; lock_seen = 0; last_pv_n = 0; to_dist = -1;
        watch8 = 0; first8_locked = 1; first8_ratio = '1;
        for (int i = 0; i < HIST; i++) xs[i] = 1'b0;

        do_reset();
        chk("reset_period", period, 0);
        chk("reset_locked", locked, 0);
        chk("reset_ratio",  ratio_onehot, 0);

        wave(1, 1, 10);
        chk("div2_period", period, 2);
        chk("div2_high",   high_time, 1);
        chk("div2_duty",   duty_ok, 1);
        chk("div2_ratio",  ratio_onehot, 5'b00001);
        chk("div2_lock_on_6th_rise", lock_pv, LOCKN + 1);

        do_reset();
        wave(16, 16, 8);
        chk("div32_period", period, 32);
        chk("div32_high",   high_time, 16);
        chk("div32_ratio",  ratio_onehot, 5'b10000);
        chk("div32_lock_on_6th_rise", lock_pv, LOCKN + 1);

        do_reset();
        wave(2, 4, 8);
        chk("div6_period", period, 6);
        chk("div6_high",   high_time, 2);
        chk("div6_duty",   duty_ok, 0);
        chk("div6_locked", locked, 1);
        chk("div6_ratio",  ratio_onehot, 0);

        do_reset();
        wave(4, 4, 8);
        chk("div8_locked", locked, 1);
        to_dist = -1;
        for (int i = 0; i < 80; i++) step(1'b0, 1'b0);
        chk("timeout_distance", to_dist, MAXP + 1);
        chk("timeout_unlocked", locked, 0);
        chk("timeout_period_held", period, 8);
        pvb = pv_cnt;
        wave(4, 4, 1);
        chk("post_timeout_no_pv", pv_cnt, pvb);

        do_reset();
        wave(2, 2, 10);
        chk("div4_ratio", ratio_onehot, 5'b00010);
        watch8 = 1;
        wave(4, 4, 8);
        chk("switch_first8_locked", first8_locked, 0);
        chk("switch_first8_ratio",  first8_ratio, 0);
        chk("relock_after_matches", lock_pv, LOCKN);
        chk("div8_ratio", ratio_onehot, 5'b00100);

        do_reset();
        wave(16 / 2, 16 / 2, 8);
        chk("div16_ratio", ratio_onehot, 5'b01000);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("midreset_period", period, 0);
        chk("midreset_high",   high_time, 0);
        chk("midreset_locked", locked, 0);
        chk("midreset_ratio",  ratio_onehot, 0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
        chk("midreset_first_rise_no_pv", pv_cnt, 0);
        wave(8, 8, 3);
        chk("midreset_not_yet_relocked", locked, 0);

        for (int s = 0; s < 40; s++) begin
            p    = $urandom_range(72, 2);
            h    = $urandom_range(p - 1, 1);
            reps = $urandom_range(6, 1);
            if ($urandom_range(24, 0) == 0) step(1'b0, 1'b1);
            for (int r = 0; r < reps; r++) begin
                for (int i = 0; i < p; i++) begin
                    bit v;
                    v = (i < h);
                    if ($urandom_range(40, 0) == 0) v = ~v;
                    step(v, 1'b0);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
